fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch PC sequencer with stall, miss and redirect handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hd_stall_i,
  input  logic        dmem_stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        imem_ack_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic        if_id_write_o,
  output logic        if_flush_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_MISS  = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_hold;
  logic        w_redirect;
  logic [31:0] w_target;

  assign w_redirect = branch_taken_i | jump_i;
  assign w_target   = {(branch_taken_i ? branch_target_i[31:2] : jump_target_i[31:2]), 2'b00};

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_hold            = 1'b0;
    imem_req_o        = 1'b0;
    if_id_write_o     = 1'b0;
    if_flush_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_FETCH;
      end
      S_FETCH, S_MISS: begin
        imem_req_o = 1'b1;
        if (!start_i) begin
          w_state_nxt      = S_IDLE;
          w_pc_nxt         = RESET_PC;
          w_pend_valid_nxt = 1'b0;
        end else if (dmem_stall_i) begin
          // Full freeze: state, PC and any redirect on this edge are ignored.
          w_hold = 1'b1;
        end else if (!imem_ack_i) begin
          w_hold        = 1'b1;
          w_state_nxt   = S_MISS;
          if_id_write_o = ~hd_stall_i;
          if_flush_o    = ~hd_stall_i;
          if (w_redirect) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = w_target;
          end
        end else begin
          w_state_nxt = S_FETCH;
          if (w_redirect || r_pend_valid) begin
            w_pc_nxt         = w_redirect ? w_target : r_pend_target;
            w_pend_valid_nxt = 1'b0;
            if_id_write_o    = 1'b1;
            if_flush_o       = 1'b1;
          end else if (hd_stall_i) begin
            w_hold = 1'b1;
          end else begin
            w_pc_nxt      = r_pc + 32'd4;
            if_id_write_o = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_pc_nxt         = RESET_PC;
        w_pend_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
      r_stall_cnt   <= 16'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      if (w_hold && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pc_o        = r_pc;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, hd_stall_i = 1'b0, dmem_stall_i = 1'b0;
  logic        branch_taken_i = 1'b0, jump_i = 1'b0, imem_ack_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0, jump_target_i = 32'h0;
  logic [31:0] pc_o;
  logic        imem_req_o, if_id_write_o, if_flush_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hd_stall_i(hd_stall_i),
    .dmem_stall_i(dmem_stall_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_ack_i(imem_ack_i), .pc_o(pc_o), .imem_req_o(imem_req_o),
    .if_id_write_o(if_id_write_o), .if_flush_o(if_flush_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic s, input logic hd, input logic dm, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt,
                       input logic ack);
    start_i = s; hd_stall_i = hd; dmem_stall_i = dm; branch_taken_i = br;
    branch_target_i = bt; jump_i = j; jump_target_i = jt; imem_ack_i = ack;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 32'h44, 0, 0, 1);
    rst_i = 1'b0;
    #2;
    n_vec++; if (pc_o !== C_RESET_PC) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc_o, C_RESET_PC); end
    n_vec++; if (state_o !== 2'b00) begin n_err++; $display("FAIL reset_state got %b exp 00", state_o); end
    n_vec++; if (stall_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", stall_cnt_o); end
    n_vec++; if ({imem_req_o, if_id_write_o, if_flush_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_comb got %b exp 000", {imem_req_o, if_id_write_o, if_flush_o}); end
    rst_i = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_vec++; if (pc_o !== exp_pc[i]) begin n_err++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_o, exp_pc[i]); end
    end
    n_vec++; if (state_o !== 2'b01) begin n_err++; $display("FAIL seq_state got %b exp 01", state_o); end
  endtask

  task automatic test_hd_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) tick();
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (if_id_write_o !== 1'b0) begin n_err++; $display("FAIL hd_write got %b exp 0", if_id_write_o); end
      tick();
      n_vec++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL hd_pc got %h exp 00000010", pc_o); end
    end
    n_vec++; if (stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL hd_cnt got %0d exp 2", stall_cnt_o); end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL hd_resume got %h exp 00000014", pc_o); end
  endtask

  task automatic test_miss_redirect();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (9) tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (state_o !== 2'b10) begin n_err++; $display("FAIL miss_state got %b exp 10", state_o); end
    drive(1, 0, 0, 1, 32'h103, 0, 0, 0);
    n_vec++; if ({if_id_write_o, if_flush_o} !== 2'b11) begin
      n_err++; $display("FAIL miss_bubble1 got %b exp 11", {if_id_write_o, if_flush_o}); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (if_flush_o !== 1'b1) begin n_err++; $display("FAIL miss_bubble2 got %b exp 1", if_flush_o); end
    tick();
    n_vec++; if (pc_o !== 32'h20) begin n_err++; $display("FAIL miss_hold got %h exp 00000020", pc_o); end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (if_flush_o !== 1'b1) begin n_err++; $display("FAIL miss_flush got %b exp 1", if_flush_o); end
    tick();
    n_vec++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL miss_target got %h exp 00000100", pc_o); end
    tick();
    n_vec++; if (pc_o !== 32'h104) begin n_err++; $display("FAIL miss_pend_clr got %h exp 00000104", pc_o); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    drive(1, 0, 0, 1, 32'h200, 1, 32'h300, 1);
    tick();
    n_vec++; if (pc_o !== 32'h200) begin n_err++; $display("FAIL prio_pc got %h exp 00000200", pc_o); end
    drive(1, 0, 0, 0, 32'h200, 1, 32'h302, 1);
    tick();
    n_vec++; if (pc_o !== 32'h300) begin n_err++; $display("FAIL jump_pc got %h exp 00000300", pc_o); end
  endtask

  task automatic test_dmem_redirect();
    logic [15:0] cnt0;
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    cnt0 = stall_cnt_o;
    drive(1, 0, 1, 1, 32'h400, 0, 0, 1);
    n_vec++; if ({if_id_write_o, if_flush_o} !== 2'b00) begin
      n_err++; $display("FAIL dmem_comb got %b exp 00", {if_id_write_o, if_flush_o}); end
    tick();
    n_vec++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL dmem_hold got %h exp 00000008", pc_o); end
    n_vec++; if (stall_cnt_o !== cnt0 + 16'd1) begin n_err++; $display("FAIL dmem_cnt got %0d exp %0d", stall_cnt_o, cnt0 + 16'd1); end
    drive(1, 0, 0, 1, 32'h400, 0, 0, 1);
    tick();
    n_vec++; if (pc_o !== 32'h400) begin n_err++; $display("FAIL dmem_apply got %h exp 00000400", pc_o); end
    drive(1, 0, 1, 0, 0, 1, 32'h800, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (pc_o !== 32'h404) begin n_err++; $display("FAIL dmem_nocapture got %h exp 00000404", pc_o); end
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 1);
    tick();
    n_vec++; if (pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre got %h exp fffffffc", pc_o); end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 00000000", pc_o); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (state_o !== 2'b00 || pc_o !== C_RESET_PC) begin
      n_err++; $display("FAIL abort got state %b pc %h exp 00 %h", state_o, pc_o, C_RESET_PC); end
    n_vec++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL abort_req got %b exp 0", imem_req_o); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    drive(1, 0, 0, 1, 32'h700, 0, 0, 0);
    tick();
    #2 rst_i = 1'b0;
    #1;
    n_vec++; if (state_o !== 2'b00 || pc_o !== C_RESET_PC) begin
      n_err++; $display("FAIL rst_async got state %b pc %h exp 00 %h", state_o, pc_o, C_RESET_PC); end
    tick();
    rst_i = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_vec++; if (imem_req_o !== 1'b1 || pc_o !== C_RESET_PC) begin
      n_err++; $display("FAIL rst_first_req got req %b pc %h exp 1 %h", imem_req_o, pc_o, C_RESET_PC); end
    tick();
    n_vec++; if (pc_o !== C_RESET_PC + 32'd4) begin n_err++; $display("FAIL rst_pend_drop got %h exp %h", pc_o, C_RESET_PC + 32'd4); end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 waiting on memory.
  task automatic test_random();
    int m_mode; logic [31:0] m_pc, m_pt; logic m_pv; int m_cnt;
    logic e_wr, e_fl, care; logic [31:0] tgt; logic s, hd, dm, br, j, ack;
    do_reset();
    m_mode = 0; m_pc = C_RESET_PC; m_pt = 0; m_pv = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = ($urandom_range(0, 15) != 0); hd = ($urandom_range(0, 3) == 0);
      dm = ($urandom_range(0, 5) == 0); br = ($urandom_range(0, 5) == 0);
      j = ($urandom_range(0, 5) == 0); ack = ($urandom_range(0, 2) != 0);
      drive(s, hd, dm, br, $urandom, j, $urandom, ack);
      tgt = (br ? branch_target_i : jump_target_i) & 32'hFFFF_FFFC;
      e_wr = 0; e_fl = 0; care = 1;
      if (m_mode == 0) begin
        if (s) m_mode = 1;
      end else if (!s) begin
        care = 0; m_mode = 0; m_pc = C_RESET_PC; m_pv = 0;
      end else if (dm) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end else if (!ack) begin
        care = (m_mode == 2); e_wr = !hd; e_fl = !hd;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        if (br || j) begin m_pv = 1; m_pt = tgt; end
        m_mode = 2;
      end else begin
        if (br || j || m_pv) begin
          m_pc = (br || j) ? tgt : m_pt; m_pv = 0; e_wr = 1; e_fl = 1;
        end else if (hd) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        else begin m_pc = m_pc + 32'd4; e_wr = 1; end
        m_mode = 1;
      end
      n_vec++; if (care && (state_o != 2'b00) && {if_id_write_o, if_flush_o} !== {e_wr, e_fl}) begin
        n_err++; $display("FAIL rnd_comb cyc %0d got %b exp %b", cyc, {if_id_write_o, if_flush_o}, {e_wr, e_fl}); end
      n_vec++; if (imem_req_o !== (state_o != 2'b00)) begin
        n_err++; $display("FAIL rnd_req cyc %0d got %b state %b", cyc, imem_req_o, state_o); end
      tick();
      n_vec++; if (pc_o !== m_pc || state_o !== m_mode[1:0] || stall_cnt_o !== m_cnt[15:0]) begin
        n_err++; $display("FAIL rnd_state cyc %0d got pc %h st %b cnt %0d exp pc %h st %0d cnt %0d",
                          cyc, pc_o, state_o, stall_cnt_o, m_pc, m_mode, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hd_stall();
    test_miss_redirect();
    test_branch_priority();
    test_dmem_redirect();
    test_wrap_and_abort();
    test_reset_mid_miss();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
